// File: rtl/branch_resolve_predict.sv
// Branch resolution (PCSrc) plus a direct-mapped saturating-counter predictor
// with branch/mispredict statistics.
module branch_resolve_predict #(
  parameter int unsigned PC_WIDTH   = 32,
  parameter int unsigned INDEX_BITS = 4,
  parameter int unsigned CTR_BITS   = 2,
  parameter int unsigned STAT_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [PC_WIDTH-1:0]   FetchPC,
  output logic                  PredictTaken,
  input  logic                  Branch,
  input  logic [2:0]            BranchType,
  input  logic [PC_WIDTH-1:0]   ResolvePC,
  input  logic                  PredictedTaken,
  input  logic                  Zero,
  input  logic                  Negative,
  input  logic                  Overflow,
  input  logic                  Carry,
  output logic                  PCSrc,
  output logic                  Mispredict,
  output logic [STAT_WIDTH-1:0] BranchCount,
  output logic [STAT_WIDTH-1:0] MispredictCount
);

  typedef enum logic [2:0] {
    BR_BEQ  = 3'b000,
    BR_BNE  = 3'b001,
    BR_JUMP = 3'b010,
    BR_RSVD = 3'b011,
    BR_BLT  = 3'b100,
    BR_BGE  = 3'b101,
    BR_BLTU = 3'b110,
    BR_BGEU = 3'b111
  } br_type_e;

  typedef logic [CTR_BITS-1:0]   ctr_t;
  typedef logic [STAT_WIDTH-1:0] stat_t;

  localparam int unsigned NUM_ENTRIES = 1 << INDEX_BITS;
  localparam ctr_t  CTR_INIT = ctr_t'((1 << (CTR_BITS - 1)) - 1);
  localparam ctr_t  CTR_ONE  = ctr_t'(1);
  localparam stat_t STAT_ONE = stat_t'(1);

  br_type_e              br_type;
  logic                  cond;
  logic [INDEX_BITS-1:0] fidx;
  logic [INDEX_BITS-1:0] ridx;
  ctr_t                  table_q [NUM_ENTRIES];
  ctr_t                  ctr_d;
  stat_t                 bcnt_q, bcnt_d;
  stat_t                 mcnt_q, mcnt_d;
  logic                  unused_pc_bits;

  assign br_type = br_type_e'(BranchType);

  always_comb begin
    cond = 1'b0;
    case (br_type)
      BR_BEQ:  cond = Zero;
      BR_BNE:  cond = !Zero;
      BR_JUMP: cond = 1'b1;
      BR_RSVD: cond = 1'b0;
      BR_BLT:  cond = Negative ^ Overflow;
      BR_BGE:  cond = !(Negative ^ Overflow);
      BR_BLTU: cond = !Carry;
      BR_BGEU: cond = Carry;
      default: cond = 1'b0;
    endcase
  end

  assign PCSrc      = Branch && cond;
  assign Mispredict = Branch && (PCSrc != PredictedTaken);

  // Word-aligned PCs: the two LSBs never select an entry, and no tag is kept.
  assign fidx = FetchPC[INDEX_BITS+1:2];
  assign ridx = ResolvePC[INDEX_BITS+1:2];
  assign unused_pc_bits = ^{FetchPC[PC_WIDTH-1:INDEX_BITS+2], FetchPC[1:0],
                            ResolvePC[PC_WIDTH-1:INDEX_BITS+2], ResolvePC[1:0]};

  // Read-before-write: a same-cycle resolve to fidx is seen next cycle.
  assign PredictTaken = table_q[fidx][CTR_BITS-1];

  always_comb begin
    ctr_d = table_q[ridx];
    if (PCSrc) begin
      if (ctr_d != '1) ctr_d = ctr_d + CTR_ONE;
    end else begin
      if (ctr_d != '0) ctr_d = ctr_d - CTR_ONE;
    end
  end

  always_comb begin
    bcnt_d = (bcnt_q != '1) ? bcnt_q + STAT_ONE : bcnt_q;
    mcnt_d = (Mispredict && (mcnt_q != '1)) ? mcnt_q + STAT_ONE : mcnt_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < NUM_ENTRIES; i++) begin
        table_q[i[INDEX_BITS-1:0]] <= CTR_INIT;
      end
      bcnt_q <= '0;
      mcnt_q <= '0;
    end else if (Branch) begin
      table_q[ridx] <= ctr_d;
      bcnt_q        <= bcnt_d;
      mcnt_q        <= mcnt_d;
    end
  end

  assign BranchCount     = bcnt_q;
  assign MispredictCount = mcnt_q;

endmodule
